// File: rtl/reduce_nor_seq_pkg.sv
// reduce_nor_seq shared types: controller state encoding and sizing helpers.
// Ports: none (package only).
package reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nslice(input int w, input int s);
    return w / s;
  endfunction

  // Slice counter needs at least one bit even for a single slice.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reduce_nor_seq_if.sv
// reduce_nor_seq operand/result bus: I_* operand handshake, O_* result
// handshake, BUSY status. master = producer/consumer side, slave = engine.
interface reduce_nor_seq_if #(
  parameter int WIDTH = 32
);
  logic             I_VALID;
  logic             I_READY;
  logic [WIDTH-1:0] I_DATA;
  logic             I_INVERT;
  logic             O_VALID;
  logic             O_READY;
  logic             O_DATA;
  logic             BUSY;

  modport master (
    output I_VALID, I_DATA, I_INVERT, O_READY,
    input  I_READY, O_VALID, O_DATA, BUSY
  );

  modport slave (
    input  I_VALID, I_DATA, I_INVERT, O_READY,
    output I_READY, O_VALID, O_DATA, BUSY
  );
endinterface

// File: rtl/reduce_nor_seq_or_slice.sv
// reduce_or_slice: combinational SLICE-to-1 OR, the shared reduce cell.
// Ports: d[SLICE] in, y out (|d).
module reduce_or_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] d,
  output logic             y
);

  // Reduced in nibble groups so each group maps onto one LUT4,
  // with the group results chained.
  localparam int NG = (SLICE + 3) / 4;

  logic [NG*4-1:0] dp;
  logic [NG-1:0]   g;

  always_comb begin
    dp = '0;
    dp[SLICE-1:0] = d;
  end

  always_comb begin
    for (int i = 0; i < NG; i++) begin
      g[i] = |dp[i*4 +: 4];
    end
  end

  assign y = |g;

endmodule

// File: rtl/reduce_nor_seq.sv
// reduce_nor_seq: sequenced OR/NOR reducer walking WIDTH bits SLICE per cycle.
// Ports: CLK, RESET (sync, active-high), io (reduce_nor_seq_if.slave).
// Option: REDUCE_NOR_SEQ_EARLY_EXIT_EN finishes on the first nonzero slice.
module reduce_nor_seq
  import reduce_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic            CLK,
  input logic            RESET,
  reduce_nor_seq_if.slave io
);

  localparam int NS = nslice(WIDTH, SLICE);
  localparam int CW = cnt_w(NS);
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             acc_q, acc_d;
  logic             inv_q, inv_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             od_q, od_d;

  logic slice_or;
  logic done_now;
  logic in_run;
  logic in_done;

  reduce_or_slice #(
    .SLICE(SLICE)
  ) u_or (
    .d(sh_q[SLICE-1:0]),
    .y(slice_or)
  );

  // Encoding 3 falls through to IDLE behaviour everywhere.
  assign in_run  = (state_q == RUN);
  assign in_done = (state_q == DONE);

`ifdef REDUCE_NOR_SEQ_EARLY_EXIT_EN
  assign done_now = (cnt_q == LAST) || slice_or;
`else
  assign done_now = (cnt_q == LAST);
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    od_d    = od_q;
    case (state_q)
      RUN: begin
        acc_d = acc_q | slice_or;
        sh_d  = sh_q >> SLICE;
        cnt_d = cnt_q + CW'(1);
        if (done_now) begin
          od_d    = (acc_q | slice_or) ^ inv_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.O_READY) begin
          state_d = IDLE;
        end
      end
      default: begin
        if (io.I_VALID) begin
          sh_d    = io.I_DATA;
          inv_d   = io.I_INVERT;
          acc_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= 1'b0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
      od_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
      od_q    <= od_d;
    end
  end

  // Ready is masked while reset is held so nothing looks accepted.
  assign io.I_READY = !in_run && !in_done && !RESET;
  assign io.O_VALID = in_done;
  assign io.O_DATA  = od_q;
  assign io.BUSY    = in_run || in_done;

endmodule

// File: tb/tb_reduce_nor_seq.sv
// tb_reduce_nor_seq: directed + random checks of reduce_nor_seq against a
// result/latency model derived from the operand value.
module tb_reduce_nor_seq;

  localparam int W  = 32;
  localparam int S  = 8;
  localparam int NS = W / S;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   stream_on = 1'b0;
  int   rc[$];
  logic rv[$];

  reduce_nor_seq_if #(.WIDTH(W)) bus ();

  reduce_nor_seq #(
    .WIDTH(W),
    .SLICE(S)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .io   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stream_on && bus.O_VALID && bus.O_READY) begin
      rc.push_back(cyc);
      rv.push_back(bus.O_DATA);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_res(input logic [W-1:0] d, input logic inv);
    return (d != 0) ^ inv;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] d);
`ifdef REDUCE_NOR_SEQ_EARLY_EXIT_EN
    for (int j = 0; j < NS; j++) begin
      if (((d >> (j * S)) & ((1 << S) - 1)) != 0) return j + 1;
    end
`endif
    return NS;
  endfunction

  task automatic run_op(input logic [W-1:0] d, input logic inv,
                        input int hold);
    int   lat;
    logic od;
    @(negedge clk);
    chk("i_ready_idle", bus.I_READY, 1);
    bus.I_VALID  = 1'b1;
    bus.I_DATA   = d;
    bus.I_INVERT = inv;
    bus.O_READY  = 1'b0;
    @(posedge clk);
    #1;
    bus.I_VALID  = 1'b0;
    bus.I_DATA   = $urandom;
    bus.I_INVERT = ~inv;
    lat = 0;
    while (!bus.O_VALID && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat(d));
    chk("o_data", bus.O_DATA, exp_res(d, inv));
    od = bus.O_DATA;
    for (int i = 0; i < hold; i++) begin
      bus.I_VALID = 1'b1;
      bus.I_DATA  = $urandom;
      @(posedge clk);
      #1;
      chk("hold_valid", bus.O_VALID, 1);
      chk("hold_data", bus.O_DATA, od);
      chk("hold_rdy", bus.I_READY, 0);
    end
    bus.I_VALID = 1'b0;
    bus.O_READY = 1'b1;
    @(posedge clk);
    #1;
    bus.O_READY = 1'b0;
    chk("idle_ovalid", bus.O_VALID, 0);
    chk("idle_busy", bus.BUSY, 0);
    chk("idle_irdy", bus.I_READY, 1);
  endtask

  logic [W-1:0] sd[8];
  logic         si[8];

  initial begin
    int idx;
    int guard;
    logic [W-1:0] d;
    bus.I_VALID  = 1'b0;
    bus.I_DATA   = '0;
    bus.I_INVERT = 1'b0;
    bus.O_READY  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irdy", bus.I_READY, 0);
    chk("rst_ovalid", bus.O_VALID, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_odata", bus.O_DATA, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_irdy", bus.I_READY, 1);

    run_op(32'h0000_0000, 1'b1, 0);
    run_op(32'h8000_0000, 1'b0, 0);
    run_op(32'h0000_0001, 1'b1, 10);

    // Abort an in-flight operand with a one-cycle reset.
    @(negedge clk);
    bus.I_VALID  = 1'b1;
    bus.I_DATA   = 32'hFFFF_FFFF;
    bus.I_INVERT = 1'b0;
    @(posedge clk);
    #1;
    bus.I_VALID = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_irdy", bus.I_READY, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ab_ovalid", bus.O_VALID, 0);
    chk("ab_busy", bus.BUSY, 0);
    chk("ab_odata", bus.O_DATA, 0);
    chk("ab_irdy", bus.I_READY, 1);
    run_op(32'h0000_0000, 1'b0, 0);
    run_op(32'h0000_0100, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0: d = '0;
        1: d = W'(1) << $urandom_range(0, W - 1);
        default: d = $urandom;
      endcase
      run_op(d, 1'($urandom), $urandom_range(0, 2));
    end

    for (int i = 0; i < 8; i++) begin
      sd[i] = ($urandom_range(0, 3) == 0) ? '0
            : (W'(1) << $urandom_range(0, W - 1));
      si[i] = 1'($urandom);
    end
    stream_on   = 1'b1;
    bus.O_READY = 1'b1;
    idx   = 0;
    guard = 0;
    while (idx < 8 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (bus.I_READY) begin
        bus.I_VALID  = 1'b1;
        bus.I_DATA   = sd[idx];
        bus.I_INVERT = si[idx];
        @(posedge clk);
        #1;
        bus.I_VALID = 1'b0;
        bus.I_DATA  = $urandom;
        idx++;
      end
    end
    guard = 0;
    while (rv.size() < 8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    stream_on = 1'b0;
    chk("s_count", rv.size(), 8);
    for (int i = 0; i < rv.size() && i < 8; i++) begin
      chk("s_data", rv[i], exp_res(sd[i], si[i]));
      if (i > 0) chk("s_space", rc[i] - rc[i-1], exp_lat(sd[i]) + 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
